// File: rtl/mul_arb.sv
// Two-requester round-robin front end for a shared two-stage multiplier.
// Tracks the single operation in the multiplier's M stage and routes its result back.
module mul_arb #(
  parameter int unsigned XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              FlushM,
  input  logic              Req0Valid,
  input  logic              Req1Valid,
  output logic              Req0Ready,
  output logic              Req1Ready,
  input  logic [XLEN-1:0]   Req0A,
  input  logic [XLEN-1:0]   Req0B,
  input  logic [XLEN-1:0]   Req1A,
  input  logic [XLEN-1:0]   Req1B,
  input  logic [2:0]        Req0Funct3,
  input  logic [2:0]        Req1Funct3,
  output logic [XLEN-1:0]   MulSrcAE,
  output logic [XLEN-1:0]   MulSrcBE,
  output logic [2:0]        MulFunct3E,
  output logic              MulStallM,
  output logic              MulFlushM,
  input  logic [2*XLEN-1:0] MulProdM,
  output logic              Rsp0Valid,
  output logic              Rsp1Valid,
  input  logic              Rsp0Ready,
  input  logic              Rsp1Ready,
  output logic [XLEN-1:0]   Rsp0Result,
  output logic [XLEN-1:0]   Rsp1Result
);

  logic last_q, last_d;
  logic m_valid_q, m_valid_d;
  logic m_tag_q, m_tag_d;
  logic m_low_q, m_low_d;

  logic gnt_e, any_gnt, hold, accept, rsp_live;
  logic [XLEN-1:0] result;

  always_comb begin
    any_gnt = Req0Valid | Req1Valid;
    // On a tie, the requester that did not win last time goes first.
    if (Req0Valid && Req1Valid) begin
      gnt_e = ~last_q;
    end else begin
      gnt_e = Req1Valid;
    end

    hold      = m_valid_q & (m_tag_q ? ~Rsp1Ready : ~Rsp0Ready);
    Req0Ready = ~gnt_e & Req0Valid & ~hold & ~reset;
    Req1Ready = gnt_e & Req1Valid & ~hold & ~reset;
    accept    = Req0Ready | Req1Ready;

    if (!any_gnt) begin
      MulSrcAE   = '0;
      MulSrcBE   = '0;
      MulFunct3E = 3'b011;
    end else if (gnt_e) begin
      MulSrcAE   = Req1A;
      MulSrcBE   = Req1B;
      MulFunct3E = Req1Funct3;
    end else begin
      MulSrcAE   = Req0A;
      MulSrcBE   = Req0B;
      MulFunct3E = Req0Funct3;
    end

    MulStallM = hold & ~reset;
    MulFlushM = FlushM | reset;
  end

  always_comb begin
    last_d    = accept ? gnt_e : last_q;
    m_valid_d = m_valid_q;
    m_tag_d   = m_tag_q;
    m_low_d   = m_low_q;
    if (!hold) begin
      m_valid_d = accept;
      m_tag_d   = gnt_e;
      m_low_d   = (MulFunct3E == 3'b000);
    end
    // A flush wins over both a held response and a fresh load.
    if (FlushM) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= 1'b1;
      m_valid_q <= 1'b0;
      m_tag_q   <= 1'b0;
      m_low_q   <= 1'b0;
    end else begin
      last_q    <= last_d;
      m_valid_q <= m_valid_d;
      m_tag_q   <= m_tag_d;
      m_low_q   <= m_low_d;
    end
  end

  always_comb begin
    rsp_live   = m_valid_q & ~FlushM & ~reset;
    Rsp0Valid  = rsp_live & ~m_tag_q;
    Rsp1Valid  = rsp_live & m_tag_q;
    result     = m_low_q ? MulProdM[XLEN-1:0] : MulProdM[2*XLEN-1:XLEN];
    Rsp0Result = result;
    Rsp1Result = result;
  end

endmodule

// File: tb/tb_mul_arb.sv
// Bench for mul_arb: a stand-in two-stage multiplier, a transaction-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_mul_arb;
  localparam int unsigned XLEN = 64;

  logic              clk = 1'b0;
  logic              reset, FlushM;
  logic              Req0Valid, Req1Valid, Req0Ready, Req1Ready;
  logic [XLEN-1:0]   Req0A, Req0B, Req1A, Req1B;
  logic [2:0]        Req0Funct3, Req1Funct3;
  logic [XLEN-1:0]   MulSrcAE, MulSrcBE;
  logic [2:0]        MulFunct3E;
  logic              MulStallM, MulFlushM;
  logic [2*XLEN-1:0] MulProdM;
  logic              Rsp0Valid, Rsp1Valid, Rsp0Ready, Rsp1Ready;
  logic [XLEN-1:0]   Rsp0Result, Rsp1Result;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mul_arb #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .FlushM(FlushM),
    .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
    .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
    .Req0A(Req0A), .Req0B(Req0B), .Req1A(Req1A), .Req1B(Req1B),
    .Req0Funct3(Req0Funct3), .Req1Funct3(Req1Funct3),
    .MulSrcAE(MulSrcAE), .MulSrcBE(MulSrcBE), .MulFunct3E(MulFunct3E),
    .MulStallM(MulStallM), .MulFlushM(MulFlushM), .MulProdM(MulProdM),
    .Rsp0Valid(Rsp0Valid), .Rsp1Valid(Rsp1Valid),
    .Rsp0Ready(Rsp0Ready), .Rsp1Ready(Rsp1Ready),
    .Rsp0Result(Rsp0Result), .Rsp1Result(Rsp1Result)
  );

  // Stand-in multiplier: E->M operand register, product formed in M.
  logic [XLEN-1:0] mul_a, mul_b;
  logic [2:0]      mul_f;
  always @(posedge clk) begin
    if (MulFlushM) begin
      mul_a <= '0;
      mul_b <= '0;
      mul_f <= 3'b011;
    end else if (!MulStallM) begin
      mul_a <= MulSrcAE;
      mul_b <= MulSrcBE;
      mul_f <= MulFunct3E;
    end
  end
  always_comb begin
    logic [2*XLEN-1:0] ea, eb;
    ea = {{XLEN{(mul_f != 3'b011) & mul_a[XLEN-1]}}, mul_a};
    eb = {{XLEN{(mul_f == 3'b000 || mul_f == 3'b001) & mul_b[XLEN-1]}}, mul_b};
    MulProdM = ea * eb;
  end

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] f);
    logic signed [127:0] sa, sb, sp;
    logic [127:0] up;
    logic [63:0] lo;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      3'b000: begin lo = a * b; return lo; end
      3'b001: begin sp = sa * sb; return sp[127:64]; end
      3'b010: begin sp = sa * $signed({64'b0, b}); return sp[127:64]; end
      default: begin up = {64'b0, a} * {64'b0, b}; return up[127:64]; end
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending response slot plus the last winner.
  logic        pend_v = 1'b0;
  logic        pend_tag = 1'b0;
  logic [63:0] pend_res = '0;
  logic        last_w = 1'b1;

  always @(negedge clk) begin
    logic winner, hold_e, r0, r1, v0, v1, acc;
    winner = (Req0Valid && Req1Valid) ? !last_w : Req1Valid;
    hold_e = pend_v && !(pend_tag ? Rsp1Ready : Rsp0Ready);
    r0 = !reset && !hold_e && Req0Valid && !winner;
    r1 = !reset && !hold_e && Req1Valid && winner;
    acc = r0 || r1;
    v0 = !reset && !FlushM && pend_v && !pend_tag;
    v1 = !reset && !FlushM && pend_v && pend_tag;
    chk("model_req0_ready", Req0Ready, r0);
    chk("model_req1_ready", Req1Ready, r1);
    chk("model_rsp0_valid", Rsp0Valid, v0);
    chk("model_rsp1_valid", Rsp1Valid, v1);
    chk("model_stall", MulStallM, !reset && hold_e);
    chk("model_flush", MulFlushM, reset || FlushM);
    if (v0) chk("model_rsp0_result", Rsp0Result, pend_res);
    if (v1) chk("model_rsp1_result", Rsp1Result, pend_res);
    if (reset) begin
      pend_v = 1'b0;
      last_w = 1'b1;
    end else begin
      if (acc) last_w = winner;
      if (FlushM) begin
        pend_v = 1'b0;
      end else if (!hold_e) begin
        pend_v   = acc;
        pend_tag = winner;
        pend_res = winner ? ref_mul(Req1A, Req1B, Req1Funct3)
                          : ref_mul(Req0A, Req0B, Req0Funct3);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_bit;
    reset = 1'b1; FlushM = 1'b0;
    Req0Valid = 1'b1; Req0A = 64'd3; Req0B = 64'd5; Req0Funct3 = 3'b000;
    Req1Valid = 1'b0; Req1A = '0; Req1B = '0; Req1Funct3 = 3'b000;
    Rsp0Ready = 1'b1; Rsp1Ready = 1'b1;

    // Reset state, then a single MUL with latency 1.
    @(negedge clk);
    chk("reset_req0_ready", Req0Ready, 0);
    chk("reset_mulflush", MulFlushM, 1);
    next(); reset = 1'b0;
    @(negedge clk);
    chk("mul_req0_ready", Req0Ready, 1);
    next(); Req0Valid = 1'b0;
    @(negedge clk);
    chk("mul_rsp0_valid", Rsp0Valid, 1);
    chk("mul_rsp0_result", Rsp0Result, 64'd15);

    // Contention from a freshly reset pointer.
    next(); reset = 1'b1;
    next(); reset = 1'b0;
    Req0Valid = 1'b1; Req0A = 64'd7; Req0B = 64'd6;
    Req1Valid = 1'b1; Req1A = 64'd2; Req1B = 64'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_bit = (i % 2 == 0);
      chk("rr_req0_ready", Req0Ready, exp_bit);
      chk("rr_req1_ready", Req1Ready, !exp_bit);
      next();
    end
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    @(negedge clk);
    chk("rr_last_rsp1", Rsp1Result, 64'd18);

    // Signed / unsigned high products, back to back on requester 1.
    next(); Req1Valid = 1'b1; Req1A = '1; Req1B = '1; Req1Funct3 = 3'b001;
    next(); Req1Funct3 = 3'b011;
    @(negedge clk);
    chk("mulh_rsp1_result", Rsp1Result, 64'd0);
    next(); Req1Funct3 = 3'b010;
    @(negedge clk);
    chk("mulhu_rsp1_result", Rsp1Result, 64'hFFFF_FFFF_FFFF_FFFE);
    next(); Req1Valid = 1'b0;

    // Backpressure on requester 0's response.
    Req0Valid = 1'b1; Req0A = 64'd11; Req0B = 64'd13; Req0Funct3 = 3'b000;
    next();
    Req0Valid = 1'b0; Rsp0Ready = 1'b0;
    Req1Valid = 1'b1; Req1A = 64'd4; Req1B = 64'd5; Req1Funct3 = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall", MulStallM, 1);
      chk("bp_req1_ready", Req1Ready, 0);
      chk("bp_rsp0_result", Rsp0Result, 64'd143);
      next();
    end
    Rsp0Ready = 1'b1;
    @(negedge clk);
    chk("bp_release_req1_ready", Req1Ready, 1);
    chk("bp_release_rsp0_valid", Rsp0Valid, 1);
    next(); Req1Valid = 1'b0;
    @(negedge clk);
    chk("bp_rsp1_result", Rsp1Result, 64'd20);

    // Flush the operation sitting in M.
    next(); Req0Valid = 1'b1; Req0A = 64'd6; Req0B = 64'd7;
    next(); Req0Valid = 1'b0; FlushM = 1'b1;
    @(negedge clk);
    chk("flush_mulflush", MulFlushM, 1);
    chk("flush_rsp0_valid", Rsp0Valid, 0);
    next(); FlushM = 1'b0;
    @(negedge clk);
    chk("flush_after_rsp0_valid", Rsp0Valid, 0);

    // Reset while a requester-1 response is held.
    next(); Req1Valid = 1'b1; Req1A = 64'd9; Req1B = 64'd9;
    next(); Req1Valid = 1'b0; Rsp1Ready = 1'b0;
    @(negedge clk);
    chk("rst_held_rsp1_valid", Rsp1Valid, 1);
    chk("rst_held_stall", MulStallM, 1);
    next(); reset = 1'b1; Req1Valid = 1'b1;
    @(negedge clk);
    chk("rst_rsp1_valid", Rsp1Valid, 0);
    chk("rst_req1_ready", Req1Ready, 0);
    chk("rst_stall", MulStallM, 0);
    chk("rst_mulflush", MulFlushM, 1);
    next(); reset = 1'b0; Rsp1Ready = 1'b1; Req0Valid = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp1_valid", Rsp1Valid, 0);
    chk("post_rst_req0_ready", Req0Ready, 1);
    chk("post_rst_req1_ready", Req1Ready, 0);
    next(); Req0Valid = 1'b0; Req1Valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_arb.md
MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the operand width; legal values are 32 and 64.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port FlushM, input, 1 bit: discard the operation held in the M stage.
REQ-005 SHALL have ports Req0Valid/Req1Valid, input, 1 bit each: requester 0/1 presents an operation.
REQ-006 SHALL have ports Req0Ready/Req1Ready, output, 1 bit each: requester 0/1 operation accepted this cycle.
REQ-007 SHALL have ports Req0A/Req0B/Req1A/Req1B, input, XLEN each: multiplicand and multiplier operands.
REQ-008 SHALL have ports Req0Funct3/Req1Funct3, input, 3 bits each: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-009 SHALL have ports MulSrcAE/MulSrcBE, output, XLEN each: operands driven to the shared two-stage multiplier.
REQ-010 SHALL have port MulFunct3E, output, 3 bits: multiply type driven to the multiplier.
REQ-011 SHALL have ports MulStallM/MulFlushM, output, 1 bit each: multiplier E->M register hold/clear.
REQ-012 SHALL have port MulProdM, input, 2*XLEN: double-width product from the multiplier, valid in M.
REQ-013 SHALL have ports Rsp0Valid/Rsp1Valid, output, 1 bit; Rsp0Ready/Rsp1Ready, input, 1 bit; Rsp0Result/Rsp1Result, output, XLEN.

Function
REQ-014 SHALL grant at most one requester per cycle; the grant is GntE (1 bit) plus AnyGnt.
REQ-015 SHALL arbitrate round-robin: if both requesters are valid, grant the one not granted last; if one is valid, grant it.
REQ-016 SHALL update the last-granted pointer only on an accepted transfer (ReqNValid & ReqNReady).
REQ-017 SHALL drive ReqNReady = (GntE==N) & ReqNValid & ~Hold, where Hold = MValid & ~RspReady[MTag].
REQ-018 SHALL mux the granted requester's A, B and Funct3 onto MulSrcAE/MulSrcBE/MulFunct3E; when neither is granted, drive zeros with Funct3 011.
REQ-019 SHALL keep an M-stage tracker: MValid, MTag (1 bit), MLow (Funct3==000), loaded with ~Hold.
REQ-020 SHALL set MValid to 1 on an accepted transfer and to 0 on a non-hold cycle with no transfer.
REQ-021 SHALL drive MulStallM = Hold, so the multiplier pipeline register freezes exactly while the tracker is held.
REQ-022 SHALL drive MulFlushM = FlushM | reset; FlushM SHALL clear MValid next edge, overriding Hold and any new load.
REQ-023 SHALL assert RspNValid = MValid & (MTag==N), combinationally, in the cycle after acceptance (latency 1).
REQ-024 SHALL drive RspNResult = MLow ? MulProdM[XLEN-1:0] : MulProdM[2*XLEN-1:XLEN], for both N, qualified only by RspNValid.
REQ-025 SHALL sustain one accepted operation per cycle when the response consumer is ready (back-to-back, alternating under contention).
REQ-026 SHALL keep RspNValid and RspNResult stable while held; a held response SHALL not be dropped or duplicated.
REQ-027 SHALL allow acceptance of a new request in the same cycle a held response is consumed (Hold deasserts combinationally).
REQ-028 SHALL not admit a requester whose Valid drops before Ready; requesters hold Valid/operands until accepted.

Reset
REQ-029 On reset high at a clock edge: MValid=0, MTag=0, MLow=0, last-granted pointer=1 (requester 0 wins first tie).
REQ-030 While reset is high: Req0Ready=Req1Ready=0, Rsp0Valid=Rsp1Valid=0, MulStallM=0, MulFlushM=1.
REQ-031 Reset mid-operation SHALL discard the in-flight M-stage operation with no response issued.

Verification
REQ-032 Single MUL: XLEN=64, Req0 A=3, B=5, Funct3=000 accepted at cycle t -> Rsp0Valid at t+1, Rsp0Result=15.
REQ-033 Contention: both valid for 4 cycles, all Rsp ready, reset pointer -> grants 0,1,0,1; responses alternate one per cycle.
REQ-034 MULH signed: Req1 A=-1, B=-1, Funct3=001 -> Rsp1Result=0; MULHU same operands -> Rsp1Result=0xFFFFFFFFFFFFFFFE.
REQ-035 Backpressure: Rsp0Ready=0 for 3 cycles with Req1Valid=1 -> MulStallM=1, Req1Ready=0, Rsp0Result stable; Rsp0Ready=1 -> Req1 accepted that cycle.
REQ-036 Flush: FlushM=1 in the cycle after acceptance -> MulFlushM=1, MValid=0 next cycle, no RspValid for that operation.
REQ-037 Reset mid-operation: reset asserted while Rsp1Valid=1 and held -> next cycle all Valid/Ready outputs 0, and the first tie after reset is granted to requester 0.
